// File: rtl/sram_arbiter.sv
// Two-requester (core / host loader) arbiter for one single-port SRAM.
// Latency: grant and mem_* are combinational; read data returns MEM_LAT+1 edges after the grant edge.
// Backpressure: a requester without gnt must hold its request; cpu_stall marks the held core cycles.
// SRAM_ARB_HOST_PRIO_EN: when defined, the host wins every tie and rr_last is removed.
module sram_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int WORD_W  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WORD_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [WORD_W-1:0] host_rdata,
    input  logic              host_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    logic cpu_elig;
    logic host_elig;
    logic cpu_win;
    logic host_win;

`ifndef SRAM_ARB_HOST_PRIO_EN
    // 1 = host was granted last; reset value lets the core win the first tie
    logic rr_last_host;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_host <= 1'b1;
        end else if (host_gnt) begin
            rr_last_host <= 1'b1;
        end else if (cpu_gnt) begin
            rr_last_host <= 1'b0;
        end
    end
`endif

    always_comb begin
        cpu_elig  = cpu_req && !host_lock;
        host_elig = host_req;
`ifdef SRAM_ARB_HOST_PRIO_EN
        host_win  = host_elig;
`else
        host_win  = host_elig && !(cpu_elig && rr_last_host);
`endif
        cpu_win   = cpu_elig && !host_win;
    end

    // Grants are forced low while reset is held so nothing reaches the SRAM
    assign cpu_gnt   = cpu_win && rst;
    assign host_gnt  = host_win && rst;
    assign cpu_stall = cpu_req && !cpu_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_gnt) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Return-tag pipe: stage MEM_LAT-1 lines up with mem_rdata of its read
    logic [MEM_LAT-1:0] tag_vld;
    logic [MEM_LAT-1:0] tag_host;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld  <= '0;
            tag_host <= '0;
        end else begin
            tag_vld[0]  <= mem_en && !mem_we;
            tag_host[0] <= host_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_host[i] <= tag_host[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            cpu_rvalid  <= tag_vld[MEM_LAT-1] && !tag_host[MEM_LAT-1];
            host_rvalid <= tag_vld[MEM_LAT-1] && tag_host[MEM_LAT-1];
            if (tag_vld[MEM_LAT-1] && !tag_host[MEM_LAT-1]) begin
                cpu_rdata <= mem_rdata;
            end
            if (tag_vld[MEM_LAT-1] && tag_host[MEM_LAT-1]) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule
